// File: rtl/fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer
//
// Write-side framebuffer port between the Mandelbrot pixel cores and the
// DDR3 interface. Pixels (RGB565) arrive one per cycle over a valid/ready
// handshake. Each pixel is clipped to the visible 1920x1080 area and turned
// into a 64-bit-word DDRAM address (16bpp, 4096-byte line stride). The
// resulting word is then queued as a single-beat masked write. A small FIFO
// absorbs DDRAM_BUSY stalls so that the cores are not stalled immediately.
//
// Optional feature, controlled by the macro FB_COALESCE_EN:
//   defined     - pixels that hit the same 64-bit word are merged in a hold
//                 register before they are queued. The hold register is
//                 pushed on eviction, on a flush pulse, or after IDLE_FLUSH
//                 cycles without an accepted pixel.
//   not defined - every accepted in-range pixel is queued directly as a
//                 single word with a 2-bit byte enable.
//
// Ports:
//   clk, reset                  system clock, async active-high reset
//   pix_valid/pix_ready         pixel handshake
//   pix_x, pix_y, pix_rgb       pixel column, row and RGB565 colour
//   flush                       pulse: push the coalescing register
//   ddram_clk                   copy of clk
//   ddram_busy                  DDRAM stall input
//   ddram_burstcnt, ddram_rd    constant 1 / constant 0
//   ddram_addr/din/be/we        head-of-queue write request
//   idle                        nothing held, nothing queued
// ---------------------------------------------------------------------------
module fb_pixel_writer #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [28:0] FB_BASE_WORD = 29'h4000000,
    parameter int          STRIDE_WORDS = 512,
    parameter int          FB_W         = 1920,
    parameter int          FB_H         = 1080,
    parameter int          IDLE_FLUSH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [15:0] pix_rgb,
    input  logic        flush,
    output logic        ddram_clk,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we,
    output logic        ddram_rd,
    output logic        idle
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0]      FB_W_C   = 11'(FB_W);
    localparam logic [10:0]      FB_H_C   = 11'(FB_H);
    localparam logic [28:0]      STRIDE_C = 29'(STRIDE_WORDS);

    // -----------------------------------------------------------------------
    // Pixel decode: word address, lane-positioned data and byte enables
    // -----------------------------------------------------------------------
    logic        inRange;
    logic        accept;
    logic        acceptIn;
    logic [28:0] pixAddr;
    logic [63:0] pixData;
    logic [7:0]  pixBe;

    assign inRange = (pix_x < FB_W_C) && (pix_y < FB_H_C);
    assign pixAddr = FB_BASE_WORD + 29'(pix_y) * STRIDE_C + 29'(pix_x[10:2]);
    assign pixData = 64'(pix_rgb) << {pix_x[1:0], 4'b0000};
    assign pixBe   = 8'b0000_0011 << {pix_x[1:0], 1'b0};

    // -----------------------------------------------------------------------
    // Write queue
    // -----------------------------------------------------------------------
    logic [28:0]      memAddr [FIFO_DEPTH];
    logic [63:0]      memData [FIFO_DEPTH];
    logic [7:0]       memBe   [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic [28:0]      pushAddr;
    logic [63:0]      pushData;
    logic [7:0]       pushBe;

    assign fifoFull  = (count_q == DEPTH_C);
    assign fifoEmpty = (count_q == '0);
    assign pop       = !fifoEmpty && !ddram_busy;
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            memAddr[wrPtr_q] <= pushAddr;
            memData[wrPtr_q] <= pushData;
            memBe[wrPtr_q]   <= pushBe;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign ddram_clk      = clk;
    assign ddram_burstcnt = 8'd1;
    assign ddram_rd       = 1'b0;
    assign ddram_we       = !fifoEmpty;
    assign ddram_addr     = fifoEmpty ? '0 : memAddr[rdPtr_q];
    assign ddram_din      = fifoEmpty ? '0 : memData[rdPtr_q];
    assign ddram_be       = fifoEmpty ? '0 : memBe[rdPtr_q];

`ifdef FB_COALESCE_EN
    // -----------------------------------------------------------------------
    // Coalescing hold register
    // -----------------------------------------------------------------------
    localparam int                IDLE_W     = $clog2(IDLE_FLUSH + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_FLUSH);

    logic              holdValid_q, holdValid_d;
    logic [28:0]       holdAddr_q, holdAddr_d;
    logic [63:0]       holdData_q, holdData_d;
    logic [7:0]        holdBe_q, holdBe_d;
    logic [IDLE_W-1:0] idleCnt_q, idleCnt_d;
    logic              flushPend_q, flushPend_d;
    logic [63:0]       pixMask;
    logic              sameWord;
    logic              evict;
    logic              flushFire;

    assign pixMask   = 64'h0000_0000_0000_FFFF << {pix_x[1:0], 4'b0000};
    assign sameWord  = holdValid_q && inRange && (pixAddr == holdAddr_q);
    assign pix_ready = !holdValid_q || sameWord || !fifoFull;
    assign accept    = pix_valid && pix_ready;
    assign acceptIn  = accept && inRange;
    assign evict     = acceptIn && holdValid_q && !sameWord;

    // An accepted pixel always wins over a flush; an explicit flush that
    // loses is kept pending, the idle timeout simply retries.
    assign flushFire = !accept && holdValid_q && !fifoFull &&
                       (flush || flushPend_q || (idleCnt_q == IDLE_LIMIT));

    assign push     = evict || flushFire;
    assign pushAddr = holdAddr_q;
    assign pushData = holdData_q;
    assign pushBe   = holdBe_q;
    assign idle     = !holdValid_q && fifoEmpty;

    // Hold register next state: load, merge into a lane, or empty on flush
    always_comb begin
        holdValid_d = holdValid_q;
        holdAddr_d  = holdAddr_q;
        holdData_d  = holdData_q;
        holdBe_d    = holdBe_q;
        if (acceptIn) begin
            holdValid_d = 1'b1;
            if (sameWord) begin
                holdData_d = (holdData_q & ~pixMask) | pixData;
                holdBe_d   = holdBe_q | pixBe;
            end else begin
                holdAddr_d = pixAddr;
                holdData_d = pixData;
                holdBe_d   = pixBe;
            end
        end else if (flushFire) begin
            holdValid_d = 1'b0;
        end
    end

    // Idle timer and pending flush request
    always_comb begin
        idleCnt_d   = idleCnt_q;
        flushPend_d = flush || flushPend_q;
        if (accept || push) begin
            idleCnt_d = '0;
        end else if (idleCnt_q != IDLE_LIMIT) begin
            idleCnt_d = idleCnt_q + IDLE_W'(1);
        end
        if (flushFire || (!accept && !holdValid_q)) begin
            flushPend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdValid_q <= 1'b0;
            holdAddr_q  <= '0;
            holdData_q  <= '0;
            holdBe_q    <= '0;
            idleCnt_q   <= '0;
            flushPend_q <= 1'b0;
        end else begin
            holdValid_q <= holdValid_d;
            holdAddr_q  <= holdAddr_d;
            holdData_q  <= holdData_d;
            holdBe_q    <= holdBe_d;
            idleCnt_q   <= idleCnt_d;
            flushPend_q <= flushPend_d;
        end
    end
`else
    // -----------------------------------------------------------------------
    // Direct path: every accepted in-range pixel becomes one queued word
    // -----------------------------------------------------------------------
    logic unusedInputs;

    assign pix_ready    = !fifoFull;
    assign accept       = pix_valid && pix_ready;
    assign acceptIn     = accept && inRange;
    assign push         = acceptIn;
    assign pushAddr     = pixAddr;
    assign pushData     = pixData;
    assign pushBe       = pixBe;
    assign idle         = fifoEmpty;
    assign unusedInputs = ^{flush, IDLE_FLUSH[0]};
`endif

endmodule
